// File: rtl/mux_4to1.sv
// mux_4to1: four-input WIDTH-bit multiplexer with a combinational result,
// a one-hot select decode, and a registered copy of the result and select
// that loads on en.
// Optional feature macro: MUX_4TO1_PARITY_EN adds parity_q, the XOR
// reduction of the value held in out_q.
module mux_4to1 #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             s0,
  input  logic             s1,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic [3:0]       sel_onehot
`ifdef MUX_4TO1_PARITY_EN
  ,
  output logic             parity_q
`endif
);

  localparam int unsigned SEL_W = 2;

  logic [SEL_W-1:0] w_sel;
  logic [WIDTH-1:0] w_out;
  logic [3:0]       w_onehot;

  logic [WIDTH-1:0] r_out_q;
  logic [SEL_W-1:0] r_sel_q;

  assign w_sel = {s1, s0};

  // Select the data input and decode the select to one-hot; defaults keep it latch-free.
  always_comb begin
    w_out    = in0;
    w_onehot = 4'b0001;
    case (w_sel)
      2'b00: begin
        w_out    = in0;
        w_onehot = 4'b0001;
      end
      2'b01: begin
        w_out    = in1;
        w_onehot = 4'b0010;
      end
      2'b10: begin
        w_out    = in2;
        w_onehot = 4'b0100;
      end
      2'b11: begin
        w_out    = in3;
        w_onehot = 4'b1000;
      end
      default: begin
        w_out    = in0;
        w_onehot = 4'b0001;
      end
    endcase
  end

  assign out        = w_out;
  assign sel_onehot = w_onehot;

  // Pipeline-boundary copy of the result and the select that produced it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= RST_VAL;
      r_sel_q <= '0;
    end else if (en) begin
      r_out_q <= w_out;
      r_sel_q <= w_sel;
    end
  end

  assign out_q = r_out_q;
  assign sel_q = r_sel_q;

`ifdef MUX_4TO1_PARITY_EN
  logic r_parity_q;

  // Parity tracks the captured value, so it loads on the same enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_q <= ^RST_VAL;
    end else if (en) begin
      r_parity_q <= ^w_out;
    end
  end

  assign parity_q = r_parity_q;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: a 1-bit and an 8-bit instance share
// clock, reset, select and enable; expectations come from an array-indexed
// reference model kept here.
module tb_mux_4to1;

  logic       clk;
  logic       rst_n;
  logic       s0, s1, en;
  logic [0:0] din1 [4];
  logic [7:0] din8 [4];

  logic [0:0] out1, out_q1;
  logic [1:0] sel_q1;
  logic [3:0] onehot1;
  logic [7:0] out8, out_q8;
  logic [1:0] sel_q8;
  logic [3:0] onehot8;
`ifdef MUX_4TO1_PARITY_EN
  logic       parity1, parity8;
`endif

  int errors = 0;
  int checks = 0;

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in0(din1[0]), .in1(din1[1]), .in2(din1[2]), .in3(din1[3]),
    .s0(s0), .s1(s1), .en(en),
    .out(out1), .out_q(out_q1), .sel_q(sel_q1), .sel_onehot(onehot1)
`ifdef MUX_4TO1_PARITY_EN
    , .parity_q(parity1)
`endif
  );

  mux_4to1 #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in0(din8[0]), .in1(din8[1]), .in2(din8[2]), .in3(din8[3]),
    .s0(s0), .s1(s1), .en(en),
    .out(out8), .out_q(out_q8), .sel_q(sel_q8), .sel_onehot(onehot8)
`ifdef MUX_4TO1_PARITY_EN
    , .parity_q(parity8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_sel(input logic [1:0] v);
    {s1, s0} = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en    = 1'b0;
    set_sel(2'b00);
    for (int i = 0; i < 4; i++) begin
      din1[i] = 1'b0;
      din8[i] = 8'h00;
    end
    #2 rst_n = 1'b0;
    #20;
    checks++;
    if (out_q8 !== 8'hA5) begin errors++; $display("FAIL reset_out_q8 got=%h exp=a5", out_q8); end
    checks++;
    if (sel_q8 !== 2'b00) begin errors++; $display("FAIL reset_sel_q8 got=%b exp=00", sel_q8); end
    checks++;
    if (out_q1 !== 1'b0) begin errors++; $display("FAIL reset_out_q1 got=%b exp=0", out_q1); end
`ifdef MUX_4TO1_PARITY_EN
    checks++;
    if (parity8 !== 1'b0) begin errors++; $display("FAIL reset_parity8 got=%b exp=0", parity8); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_sweep();
    logic [0:0] exp_out [4];
    logic [3:0] exp_oh  [4];
    exp_out[0] = 1'b1; exp_out[1] = 1'b0; exp_out[2] = 1'b1; exp_out[3] = 1'b0;
    exp_oh[0]  = 4'b0001; exp_oh[1] = 4'b0010; exp_oh[2] = 4'b0100; exp_oh[3] = 4'b1000;
    din1[0] = 1'b1; din1[1] = 1'b0; din1[2] = 1'b1; din1[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_sel(2'(i));
      #100;
      checks++;
      if (out1 !== exp_out[i]) begin errors++; $display("FAIL sweep_out sel=%0d got=%b exp=%b", i, out1, exp_out[i]); end
      checks++;
      if (onehot1 !== exp_oh[i]) begin errors++; $display("FAIL sweep_onehot sel=%0d got=%b exp=%b", i, onehot1, exp_oh[i]); end
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    din8[0] = 8'h11; din8[1] = 8'h22; din8[2] = 8'h33; din8[3] = 8'h44;
    set_sel(2'b10);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    checks++;
    if (out_q8 !== 8'h33) begin errors++; $display("FAIL capture_out_q got=%h exp=33", out_q8); end
    checks++;
    if (sel_q8 !== 2'b10) begin errors++; $display("FAIL capture_sel_q got=%b exp=10", sel_q8); end
  endtask

  task automatic test_hold();
    set_sel(2'b11);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out8 !== 8'h44) begin errors++; $display("FAIL hold_out got=%h exp=44", out8); end
    checks++;
    if (out_q8 !== 8'h33) begin errors++; $display("FAIL hold_out_q got=%h exp=33", out_q8); end
    checks++;
    if (sel_q8 !== 2'b10) begin errors++; $display("FAIL hold_sel_q got=%b exp=10", sel_q8); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_q8 !== 8'hA5) begin errors++; $display("FAIL async_out_q got=%h exp=a5", out_q8); end
    checks++;
    if (sel_q8 !== 2'b00) begin errors++; $display("FAIL async_sel_q got=%b exp=00", sel_q8); end
    checks++;
    if (out8 !== 8'h44) begin errors++; $display("FAIL async_out_sel3 got=%h exp=44", out8); end
    set_sel(2'b01);
    #1;
    checks++;
    if (out8 !== 8'h22) begin errors++; $display("FAIL async_out_sel1 got=%h exp=22", out8); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_vs_enable();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    set_sel(2'b11);
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_q8 !== 8'hA5) begin errors++; $display("FAIL rst_over_en_out_q got=%h exp=a5", out_q8); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_sel(2'b01);
    @(posedge clk);
    #1 en = 1'b0;
    checks++;
    if (out_q8 !== 8'h22) begin errors++; $display("FAIL release_out_q got=%h exp=22", out_q8); end
    checks++;
    if (sel_q8 !== 2'b01) begin errors++; $display("FAIL release_sel_q got=%b exp=01", sel_q8); end
  endtask

`ifdef MUX_4TO1_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    din8[0] = 8'h07;
    set_sel(2'b00);
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (parity8 !== 1'b1) begin errors++; $display("FAIL parity_07 got=%b exp=1", parity8); end
    din8[0] = 8'h03;
    @(posedge clk);
    #1 en = 1'b0;
    checks++;
    if (parity8 !== 1'b0) begin errors++; $display("FAIL parity_03 got=%b exp=0", parity8); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_q8;
    logic [0:0] exp_q1;
    logic [1:0] exp_sel;
    int         sel;
    logic       en_v;
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    #1 rst_n = 1'b1;
    exp_q8 = 8'hA5; exp_q1 = 1'b0; exp_sel = 2'b00;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        din8[i] = 8'($urandom);
        din1[i] = 1'($urandom);
      end
      sel  = int'($urandom_range(3, 0));
      en_v = 1'($urandom);
      set_sel(2'(sel));
      en = en_v;
      #1;
      checks++;
      if (out8 !== din8[sel]) begin errors++; $display("FAIL rand_out8 n=%0d got=%h exp=%h", n, out8, din8[sel]); end
      checks++;
      if (out1 !== din1[sel]) begin errors++; $display("FAIL rand_out1 n=%0d got=%b exp=%b", n, out1, din1[sel]); end
      checks++;
      if (onehot8 !== 4'(1 << sel)) begin errors++; $display("FAIL rand_onehot n=%0d got=%b exp=%b", n, onehot8, 4'(1 << sel)); end
      if (en_v) begin
        exp_q8  = din8[sel];
        exp_q1  = din1[sel];
        exp_sel = 2'(sel);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_q8 !== exp_q8) begin errors++; $display("FAIL rand_out_q8 n=%0d got=%h exp=%h", n, out_q8, exp_q8); end
      checks++;
      if (out_q1 !== exp_q1) begin errors++; $display("FAIL rand_out_q1 n=%0d got=%b exp=%b", n, out_q1, exp_q1); end
      checks++;
      if (sel_q8 !== exp_sel) begin errors++; $display("FAIL rand_sel_q8 n=%0d got=%b exp=%b", n, sel_q8, exp_sel); end
      checks++;
      if (sel_q1 !== exp_sel) begin errors++; $display("FAIL rand_sel_q1 n=%0d got=%b exp=%b", n, sel_q1, exp_sel); end
`ifdef MUX_4TO1_PARITY_EN
      checks++;
      if (parity8 !== ^exp_q8) begin errors++; $display("FAIL rand_parity8 n=%0d got=%b exp=%b", n, parity8, ^exp_q8); end
      checks++;
      if (parity1 !== ^exp_q1) begin errors++; $display("FAIL rand_parity1 n=%0d got=%b exp=%b", n, parity1, ^exp_q1); end
`endif
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_capture();
    test_hold();
    test_async_reset();
    test_reset_vs_enable();
`ifdef MUX_4TO1_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
